// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: segment codes,
// scan FSM encoding and digit count.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         DIG_NUM = 8;

  // Active-low codes for 0..F with dp (bit7) off; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } seg_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Nibble plus decimal point to active-low seven-segment code.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = SEG_HEX[i_nib] & {~i_dp, 7'h7F};

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner with blanking gap and
// frame-aligned double-buffered display data.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iData,
  input  logic [7:0]  iDigEn,
  input  logic [7:0]  iDp,
  input  logic        iLoad,
  output logic [2:0]  oDigSel,
  output logic        oDigValid,
  output logic [7:0]  oSeg,
  output logic        oFrame,
  output logic        oPending
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(DIG_NUM - 1);

  seg_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic             w_commit;

  logic [31:0] r_shd_data, r_act_data, w_act_data_nxt;
  logic [7:0]  r_shd_en, r_act_en, w_act_en_nxt;
  logic [7:0]  r_shd_dp, r_act_dp, w_act_dp_nxt;
  logic        r_pending;

  logic [3:0] w_nib;
  logic       w_dp;
  logic [7:0] w_code;
  logic       w_show_nxt, w_frame_nxt;
  logic [7:0] r_seg;
  logic       r_valid, r_frame;

  // Phase counter / digit index sequencing; commit is the 7->0 wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_commit    = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 3'd1;
          w_commit    = (r_idx == IDX_LAST);
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Active buffer takes the pre-existing shadow only at a commit with data pending.
  always_comb begin
    if (w_commit && r_pending) begin
      w_act_data_nxt = r_shd_data;
      w_act_en_nxt   = r_shd_en;
      w_act_dp_nxt   = r_shd_dp;
    end else begin
      w_act_data_nxt = r_act_data;
      w_act_en_nxt   = r_act_en;
      w_act_dp_nxt   = r_act_dp;
    end
  end

  // Outputs are computed from next-state values so the registers line up with the current cycle.
  assign w_nib       = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_dp        = w_act_dp_nxt[w_idx_nxt];
  assign w_show_nxt  = (w_state_nxt == ST_SHOW) && w_act_en_nxt[w_idx_nxt];
  assign w_frame_nxt = (w_state_nxt == ST_SHOW) && (w_idx_nxt == IDX_LAST) &&
                       (w_cnt_nxt == SHOW_LAST);

  hex_to_seg u_hex (
    .i_nib (w_nib),
    .i_dp  (w_dp),
    .o_seg (w_code)
  );

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BLANK;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_shd_data <= 32'h0;
      r_shd_en   <= 8'h00;
      r_shd_dp   <= 8'h00;
      r_act_data <= 32'h0;
      r_act_en   <= 8'h00;
      r_act_dp   <= 8'h00;
      r_pending  <= 1'b0;
      r_seg      <= SEG_OFF;
      r_valid    <= 1'b0;
      r_frame    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_act_data <= w_act_data_nxt;
      r_act_en   <= w_act_en_nxt;
      r_act_dp   <= w_act_dp_nxt;
      if (iLoad) begin
        r_shd_data <= iData;
        r_shd_en   <= iDigEn;
        r_shd_dp   <= iDp;
        r_pending  <= 1'b1;
      end else if (w_commit) begin
        r_pending  <= 1'b0;
      end else begin
        r_pending  <= r_pending;
      end
      r_seg   <= w_show_nxt ? w_code : SEG_OFF;
      r_valid <= w_show_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  assign oDigSel   = r_idx;
  assign oDigValid = r_valid;
  assign oSeg      = r_seg;
  assign oFrame    = r_frame;
  assign oPending  = r_pending;

endmodule
